traffic_ctrl_gen: RTL
=====================

# traffic_ctrl_gen

Parametrised single-intersection traffic-light sequencer. It generates its own 1-of-TICK_DIV timing tick from `clk` and steps through GREEN, YELLOW and RED phases with configurable durations. It adds a pedestrian-request green shortening and a flashing-yellow maintenance mode. It drives the seven-segment countdown decoder (`count`) and the dot-matrix pictogram driver (`state`) in the lab top level.

## Interface
- `TICK_DIV`, 50000000: `clk` cycles per tick (one second at 50 MHz); ≥2.
- `CNT_W`, 4: countdown width; must hold max(GREEN_T, YELLOW_T, RED_T) − 1.
- `GREEN_T`, 15: GREEN duration in ticks; ≥1.
- `YELLOW_T`, 5: YELLOW duration in ticks; ≥1.
- `RED_T`, 10: RED duration in ticks; ≥1.
- `PED_T`, 3: remaining GREEN ticks after a pedestrian request; 1 ≤ PED_T ≤ GREEN_T.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  run enable; low freezes the prescaler, so no ticks occur.
- `ped_req`  in  1  pedestrian button, level or pulse, already synchronised.
- `flash_mode`  in  1  request for flashing-yellow maintenance mode.
- `state`  out  2  0=GREEN, 1=YELLOW, 2=RED, 3=FLASH.
- `count`  out  CNT_W  remaining ticks in the current phase minus 1.
- `tick`  out  1  one-cycle pulse for each prescaler wrap.
- `lamp_r`, `lamp_y`, `lamp_g`  out  1 each  lamp drives, active-high.
- `ped_ack`  out  1  one-cycle pulse when a latched pedestrian request is served.

## Operation
- **Prescaler**
  - `div_cnt` counts 0..TICK_DIV−1 while `en`=1 and holds while `en`=0.
  - `tick`=1 in the cycle `div_cnt` is TICK_DIV−1 and `en`=1.
  - `div_cnt` wraps to 0 in the same cycle.
- **Phase countdown**
  - On phase entry, `count` loads duration−1.
  - Each tick, `count` decrements.
  - A tick with `count`==0 transitions the phase. Each phase therefore lasts exactly its duration in ticks.
- **Transitions on tick with `count`==0**
  - GREEN→YELLOW, loads YELLOW_T−1.
  - YELLOW→RED, loads RED_T−1.
  - RED→GREEN, loads GREEN_T−1.
- **Pedestrian request**
  - Any cycle with `ped_req`=1 sets `ped_pend`.
  - In GREEN, on a tick with `ped_pend`=1 and `count` > PED_T−1, `count` loads PED_T−1 instead of decrementing. The shortening applies at most once per GREEN, because it only fires while the count is above the floor.
  - `ped_pend` clears and `ped_ack` pulses in the cycle the state enters RED.
  - A `ped_req` asserted in that same cycle is lost.
  - Requests during YELLOW or RED stay pending for the next GREEN.
- **FLASH mode**
  - `flash_mode`=1 in any non-FLASH state moves to FLASH on the next clock edge, whether or not a tick occurs.
  - In FLASH, `count` is held at 0.
  - `flash_ph` toggles on every tick.
  - `ped_pend` is retained.
  - FLASH with `flash_mode`=0 exits on the next tick to RED, loading RED_T−1 (safe re-entry).
  - `flash_mode` takes priority over a same-cycle phase transition.
- **Lamps** are decoded combinationally from registers:
  - GREEN → g=1
  - YELLOW → y=1
  - RED → r=1
  - FLASH → y=`flash_ph`, r=g=0
  - Exactly one lamp is on outside FLASH.

## Timing
- **Reset (synchronous, `reset`=0 at an edge)**, takes priority over everything:
  - `div_cnt`=0, `state`=0 (GREEN), `count`=GREEN_T−1
  - `ped_pend`=0, `flash_ph`=0, `tick`=0, `ped_ack`=0
  - lamps g=1, r=y=0
  - Reset mid-phase or mid-FLASH behaves identically.
- **Latency**
  - `state` and `count` update on the edge where `tick`=1 is sampled high; the new values are visible the cycle after the tick pulse.
  - `ped_req` is latched with 1-cycle latency. The shortening happens on the first tick after the latch.
  - `flash_mode` has 1-cycle latency to `state`=3.
- **Arithmetic**
  - `count` is CNT_W-bit unsigned and never underflows, because it is reloaded at 0.
  - `div_cnt` width is $clog2(TICK_DIV).
  - `en`=0 freezes all state except the `ped_pend` latch and FLASH entry.

## Test plan
Bench parameters: TICK_DIV=4, GREEN_T=15, YELLOW_T=5, RED_T=10, PED_T=3.

1. **Reset then free run:** release reset with `en`=1 → `tick` every 4th cycle. `state` sequence 0 (15 ticks), 1 (5), 2 (10), 0. `count` runs 14..0, 4..0, 9..0. Full cycle is 120 clocks.
2. **Pedestrian request:** pulse `ped_req` at GREEN `count`=10 → next tick `count`=2, then 1, 0, then YELLOW. `ped_ack` pulses once on RED entry; none on the next cycle.
3. **Late request and retention:**
   - Request at GREEN `count`=1 → no shortening, `ped_ack` at RED entry.
   - Request during RED → GREEN shortened to 3 ticks on its first tick.
4. **FLASH entry and exit:**
   - Assert `flash_mode` at YELLOW `count`=3 → `state`=3 the next cycle, `count`=0, `lamp_y` toggles every 4 clocks.
   - Deassert → next tick `state`=2, `count`=9.
5. **Enable hold:** drop `en` for 20 cycles mid-RED → `state`, `count`, `div_cnt` unchanged and no `tick`. Resume continues exactly where it stopped.
6. **Mid-run reset:** pull `reset` low at RED `count`=5 for one edge → next cycle `state`=0, `count`=14, `lamp_g`=1, `ped_pend` cleared.

Source files
------------

// File: rtl/traffic_ctrl_gen.sv
// Single-intersection traffic-light sequencer with an internal tick prescaler,
// a pedestrian green-shortening request and a flashing-yellow maintenance mode.
module traffic_ctrl_gen #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned GREEN_T  = 15,
  parameter int unsigned YELLOW_T = 5,
  parameter int unsigned RED_T    = 10,
  parameter int unsigned PED_T    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ped_req,
  input  logic             flash_mode,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             lamp_r,
  output logic             lamp_y,
  output logic             lamp_g,
  output logic             ped_ack
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T - 1);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    FLASH  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ped_pend_q, ped_pend_d;
  logic             flash_ph_q, flash_ph_d;
  logic             ped_ack_q, ped_ack_d;

  assign tick = en && (div_q == DIV_MAX);

  always_comb begin
    div_d      = div_q;
    state_d    = state_q;
    count_d    = count_q;
    flash_ph_d = flash_ph_q;
    ped_pend_d = ped_pend_q | ped_req;
    ped_ack_d  = 1'b0;

    if (en) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // FLASH entry bypasses the tick and the enable, and pre-empts any phase change.
    if (flash_mode && (state_q != FLASH)) begin
      state_d = FLASH;
      count_d = '0;
    end else if (tick) begin
      unique case (state_q)
        GREEN: begin
          if (count_q == '0) begin
            state_d = YELLOW;
            count_d = YELLOW_LD;
          end else if (ped_pend_q && (count_q > PED_LD)) begin
            count_d = PED_LD;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        YELLOW: begin
          if (count_q == '0) begin
            state_d = RED;
            count_d = RED_LD;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        RED: begin
          if (count_q == '0) begin
            state_d = GREEN;
            count_d = GREEN_LD;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        FLASH: begin
          flash_ph_d = ~flash_ph_q;
          if (!flash_mode) begin
            state_d = RED;
            count_d = RED_LD;
          end
        end
        default: ;
      endcase
    end

    // A request is served on every RED entry; a same-cycle ped_req is dropped.
    if ((state_d == RED) && (state_q != RED)) begin
      ped_ack_d  = ped_pend_q;
      ped_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      state_q    <= GREEN;
      count_q    <= GREEN_LD;
      ped_pend_q <= 1'b0;
      flash_ph_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      count_q    <= count_d;
      ped_pend_q <= ped_pend_d;
      flash_ph_q <= flash_ph_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  always_comb begin
    lamp_r = 1'b0;
    lamp_y = 1'b0;
    lamp_g = 1'b0;
    unique case (state_q)
      GREEN:   lamp_g = 1'b1;
      YELLOW:  lamp_y = 1'b1;
      RED:     lamp_r = 1'b1;
      FLASH:   lamp_y = flash_ph_q;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign count   = count_q;
  assign ped_ack = ped_ack_q;

endmodule
